// File: rtl/uart_tx_arb_if.sv
// Requester/transmitter bundle for uart_tx_arb: byte sources on one side, uart_tx start/data/ready on the other.
interface uart_tx_arb_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_last;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ack;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_ready;

  modport master (
    input  req_valid, req_last, req_data, tx_ready,
    output req_ack, grant, busy, tx_start, tx_data
  );

  modport slave (
    output req_valid, req_last, req_data, tx_ready,
    input  req_ack, grant, busy, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin, packet-locked arbiter feeding one uart_tx from NREQ byte sources.
// Optional mid-packet stall release: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arb #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rstn,
  uart_tx_arb_if.master bus
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_cfg_err
    $error("uart_tx_arb: NREQ must be 2..8 and TIMEOUT at least 2");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t          state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   ptr;
  logic            last_q;
  logic [7:0]      req_byte [NREQ];
  logic [IW-1:0]   pick_c;
  logic            any_c;
  logic [IW-1:0]   next_ptr_c;
  logic            owner_valid_c;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] stall_cnt;
`endif

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_byte[i] = bus.req_data[8*i +: 8];
    end
  end

  // First requesting index at or after ptr, wrapping modulo NREQ.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    pick_c = '0;
    any_c  = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!any_c && bus.req_valid[IW'(idx)]) begin
        any_c  = 1'b1;
        pick_c = IW'(idx);
      end
    end
  end

  assign next_ptr_c    = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
  assign owner_valid_c = bus.req_valid[owner];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      owner        <= '0;
      ptr          <= '0;
      last_q       <= 1'b0;
      bus.grant    <= '0;
      bus.busy     <= 1'b0;
      bus.req_ack  <= '0;
      bus.tx_start <= 1'b0;
      bus.tx_data  <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      stall_cnt    <= '0;
`endif
    end else begin
      bus.tx_start <= 1'b0;
      bus.req_ack  <= '0;
      case (state)
        IDLE: begin
          if (any_c) begin
            owner     <= pick_c;
            bus.grant <= NREQ'(1) << pick_c;
            bus.busy  <= 1'b1;
            state     <= SEND;
          end
        end

        SEND: begin
          if (bus.tx_ready && owner_valid_c) begin
            bus.tx_data  <= req_byte[owner];
            bus.tx_start <= 1'b1;
            bus.req_ack  <= NREQ'(1) << owner;
            last_q       <= bus.req_last[owner];
            state        <= WAIT_BUSY;
`ifdef UART_TX_ARB_TIMEOUT_EN
            stall_cnt    <= '0;
          end else if (!owner_valid_c) begin
            // Owner has gone quiet mid-packet: give the line to someone else.
            if (stall_cnt == CW'(TIMEOUT - 1)) begin
              stall_cnt <= '0;
              bus.grant <= '0;
              bus.busy  <= 1'b0;
              ptr       <= next_ptr_c;
              state     <= IDLE;
            end else begin
              stall_cnt <= stall_cnt + CW'(1);
            end
`endif
          end
        end

        // Capture cycle lands here, so the acked byte is never sampled twice.
        WAIT_BUSY: begin
          if (!bus.tx_ready) begin
            state <= WAIT_DONE;
          end
        end

        WAIT_DONE: begin
          if (bus.tx_ready) begin
            if (last_q) begin
              bus.grant <= '0;
              bus.busy  <= 1'b0;
              ptr       <= next_ptr_c;
              state     <= IDLE;
            end else begin
              state <= SEND;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
